// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared field positions, opcodes, PSR indices, FSM states and decoder.
// Contents: instruction field bounds, op/ext constants, PSR bit indices and masks,
//           state_e enum, dec_t decode record and the decode() helper.
package alu_issue_pkg;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int EXT_MSB = 7;
    localparam int EXT_LSB = 4;
    localparam int RS_MSB  = 3;
    localparam int RS_LSB  = 0;

    localparam logic [3:0] OP_REG       = 4'h0;
    localparam logic [3:0] OP_SHIFT     = 4'h8;
    localparam logic [3:0] OP_LUI       = 4'hF;
    localparam logic [3:0] OP_LOADSTORE = 4'h4;

    // The immediate-form op codes reuse the register-form ext codes.
    localparam logic [3:0] EXT_AND  = 4'h1;
    localparam logic [3:0] EXT_OR   = 4'h2;
    localparam logic [3:0] EXT_XOR  = 4'h3;
    localparam logic [3:0] EXT_ADD  = 4'h5;
    localparam logic [3:0] EXT_ADDU = 4'h6;
    localparam logic [3:0] EXT_SUB  = 4'h9;
    localparam logic [3:0] EXT_CMP  = 4'hB;
    localparam logic [3:0] EXT_MOV  = 4'hD;

    localparam int PSR_C = 0;
    localparam int PSR_L = 1;
    localparam int PSR_F = 2;
    localparam int PSR_Z = 3;
    localparam int PSR_N = 4;

    localparam logic [4:0] PSR_ADD_MASK = 5'(1 << PSR_F);
    localparam logic [4:0] PSR_CMP_MASK = 5'((1 << PSR_L) | (1 << PSR_Z) | (1 << PSR_N));

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WB} state_e;

    typedef struct packed {
        logic       legal;
        logic [7:0] opc;
        logic       imm_b;
        logic       zext;
        logic       we;
        logic [4:0] psr_mask;
    } dec_t;

    function automatic dec_t decode(input logic [15:0] ins);
        dec_t       d;
        logic [3:0] op;
        logic [3:0] ext;
        logic [3:0] cls;
        logic       imm_op;
        op     = ins[OP_MSB:OP_LSB];
        ext    = ins[EXT_MSB:EXT_LSB];
        imm_op = op inside {EXT_AND, EXT_OR, EXT_XOR, EXT_ADD, EXT_ADDU, EXT_SUB, EXT_CMP, EXT_MOV};
        // cls is the arithmetic class that drives writeback/PSR; shifts and LUI map to none.
        cls        = (op == OP_REG) ? ext : (imm_op ? op : 4'h0);
        d.legal    = (op == OP_REG) || (op == OP_SHIFT) || (op == OP_LUI) || imm_op;
        d.opc      = (op == OP_REG) ? {4'h0, ext} : (op == OP_SHIFT) ? {4'h8, ext} :
                     (op == OP_LUI) ? 8'hF0 : {4'h0, op};
        d.imm_b    = imm_op || (op == OP_LUI);
        d.zext     = (op == OP_LUI);
        d.we       = d.legal && (cls != EXT_CMP);
        d.psr_mask = (cls == EXT_ADD) ? PSR_ADD_MASK : (cls == EXT_CMP) ? PSR_CMP_MASK : 5'b0;
        return d;
    endfunction

endpackage

// File: rtl/alu_issue_wb_regfile16.sv
// regfile16: register file with two combinational read ports, a debug read port and one sync write port.
// Ports: clock, reset (sync, clears all registers), ra/rb/dbg address+data reads, we/wa/wd write.
// Option: ALU_ISSUE_R0_ZERO_EN makes R0 read as zero and discards writes to it.
module regfile16 #(
    parameter int NREGS = 16,
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       ra_addr,
    input  logic [3:0]       rb_addr,
    input  logic [3:0]       dbg_addr,
    output logic [WIDTH-1:0] ra_data,
    output logic [WIDTH-1:0] rb_data,
    output logic [WIDTH-1:0] dbg_data,
    input  logic             we,
    input  logic [3:0]       wa,
    input  logic [WIDTH-1:0] wd
);

`ifdef ALU_ISSUE_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif

    logic [WIDTH-1:0] mem_q [NREGS];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
        end else if (we && !(R0Z && wa == 4'h0)) begin
            mem_q[wa] <= wd;
        end
    end

    assign ra_data  = (R0Z && ra_addr  == 4'h0) ? '0 : mem_q[ra_addr];
    assign rb_data  = (R0Z && rb_addr  == 4'h0) ? '0 : mem_q[rb_addr];
    assign dbg_data = (R0Z && dbg_addr == 4'h0) ? '0 : mem_q[dbg_addr];

endmodule

// File: rtl/alu_issue_wb.sv
// alu_issue_wb: serial decode/issue/writeback stage wrapped around an external registered ALU.
// Ports: clock, reset (sync active-high); instr_valid/instr/instr_ready handshake;
//        alu_opcode/alu_a/alu_b to the ALU, alu_result/alu_psr back from it;
//        psr architectural flags, illegal one-cycle pulse, dbg_addr/dbg_data register peek.
// Option: ALU_ISSUE_R0_ZERO_EN (handled in regfile16) hardwires R0 to zero.
module alu_issue_wb
    import alu_issue_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [15:0]      instr,
    output logic             instr_ready,
    output logic [7:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [4:0]       alu_psr,
    output logic [4:0]       psr,
    output logic             illegal,
    input  logic [3:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    state_e           state_q, state_d;
    dec_t             dec;
    logic             accept, busy;
    logic [WIDTH-1:0] ra_data, rb_data, b_src;
    logic [7:0]       opc_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [3:0]       rd_q;
    logic             we_q;
    logic [4:0]       mask_q, psr_q;
    logic             illegal_q;

    assign dec    = decode(instr);
    assign accept = (state_q == S_IDLE) && instr_valid;
    assign b_src  = !dec.imm_b ? rb_data :
                    dec.zext   ? {{(WIDTH-8){1'b0}}, instr[7:0]} : {{(WIDTH-8){instr[7]}}, instr[7:0]};

    regfile16 #(.NREGS(NREGS), .WIDTH(WIDTH)) u_rf (
        .clock    (clock),
        .reset    (reset),
        .ra_addr  (instr[RD_MSB:RD_LSB]),
        .rb_addr  (instr[RS_MSB:RS_LSB]),
        .dbg_addr (dbg_addr),
        .ra_data  (ra_data),
        .rb_data  (rb_data),
        .dbg_data (dbg_data),
        .we       ((state_q == S_WB) && we_q),
        .wa       (rd_q),
        .wd       (alu_result)
    );

    always_ff @(posedge clock) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = (state_q == S_IDLE)  ? ((accept && dec.legal) ? S_ISSUE : S_IDLE) :
                  (state_q == S_ISSUE) ? S_WB : S_IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            opc_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rd_q      <= '0;
            we_q      <= 1'b0;
            mask_q    <= '0;
            psr_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= accept && !dec.legal;
            if (accept && dec.legal) begin
                opc_q  <= dec.opc;
                a_q    <= ra_data;
                b_q    <= b_src;
                rd_q   <= instr[RD_MSB:RD_LSB];
                we_q   <= dec.we;
                mask_q <= dec.psr_mask;
            end
            // Only the flag bits owned by the instruction class are refreshed.
            if (state_q == S_WB) psr_q <= (psr_q & ~mask_q) | (alu_psr & mask_q);
        end
    end

    // Outside ISSUE/WB the ALU sees an all-zero opcode and operands.
    always_comb begin
        busy        = (state_q != S_IDLE);
        instr_ready = !busy;
        alu_opcode  = busy ? opc_q : 8'h00;
        alu_a       = busy ? a_q : '0;
        alu_b       = busy ? b_q : '0;
        psr         = psr_q;
        illegal     = illegal_q;
    end

endmodule

// File: tb/tb_alu_issue_wb.sv
// tb_alu_issue_wb: directed plus random checks of alu_issue_wb against an instruction-level model.
module tb_alu_issue_wb;

`ifdef ALU_ISSUE_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = 16'h0;
    logic        instr_ready;
    logic [7:0]  alu_opcode;
    logic [15:0] alu_a, alu_b;
    logic [15:0] alu_result = 16'h0;
    logic [4:0]  alu_psr = 5'h0;
    logic [4:0]  psr;
    logic        illegal;
    logic [3:0]  dbg_addr = 4'h0;
    logic [15:0] dbg_data;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] mr [16];
    logic [4:0]  mpsr;

    logic        bi, bw;
    logic [7:0]  bo;
    logic [15:0] ba, bb;
    logic [4:0]  bm;

    alu_issue_wb dut (
        .clock       (clock),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .alu_opcode  (alu_opcode),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_result  (alu_result),
        .alu_psr     (alu_psr),
        .psr         (psr),
        .illegal     (illegal),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] alu_fn(input logic [7:0] o, input logic [15:0] a, input logic [15:0] b);
        case (o)
            8'h01:        return a & b;
            8'h02:        return a | b;
            8'h03:        return a ^ b;
            8'h05, 8'h06: return a + b;
            8'h09, 8'h0B: return a - b;
            8'h0D:        return b;
            8'hF0:        return {b[7:0], a[7:0]};
            default:      return (o[7:4] == 4'h8) ? (a << b[3:0]) : (a ^ b ^ 16'h3C3C);
        endcase
    endfunction

    function automatic logic [4:0] psr_fn(input logic [7:0] o, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b} + {16'h0, o[0]};
        return {$signed(a) < $signed(b), a == b, (a[15] == b[15]) && (s[15] != a[15]), a < b, s[16]};
    endfunction

    // Registered ALU: result of the operands it saw at the previous edge.
    always @(posedge clock) begin
        alu_result <= alu_fn(alu_opcode, alu_a, alu_b);
        alu_psr    <= psr_fn(alu_opcode, alu_a, alu_b);
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic dbg_chk(input string tag, input logic [3:0] ad);
        dbg_addr = ad;
        #1;
        chk(tag, dbg_data, mr[ad]);
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 16; i++) dbg_chk(tag, 4'(i));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mr[i] = 16'h0;
        mpsr = 5'h0;
    endtask

    // Instruction-level decode from the architectural rules.
    task automatic mdec(input logic [15:0] ins, output logic ill, output logic [7:0] opc,
                        output logic [15:0] a, output logic [15:0] b, output logic we, output logic [4:0] mask);
        logic [3:0] op, rd, ext, rs;
        logic [7:0] imm;
        {op, rd, ext, rs} = ins;
        imm  = ins[7:0];
        ill  = 1'b0;
        opc  = 8'h0;
        a    = mr[rd];
        b    = 16'h0;
        we   = 1'b1;
        mask = 5'h0;
        case (op)
            4'h0: begin
                opc  = {4'h0, ext};
                b    = mr[rs];
                we   = (ext != 4'hB);
                mask = (ext == 4'h5) ? 5'b00100 : (ext == 4'hB) ? 5'b11010 : 5'b0;
            end
            4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h9, 4'hB, 4'hD: begin
                opc  = {4'h0, op};
                b    = {{8{imm[7]}}, imm};
                we   = (op != 4'hB);
                mask = (op == 4'h5) ? 5'b00100 : (op == 4'hB) ? 5'b11010 : 5'b0;
            end
            4'h8: begin
                opc = {4'h8, ext};
                b   = mr[rs];
            end
            4'hF: begin
                opc = 8'hF0;
                b   = {8'h0, imm};
            end
            default: begin
                ill = 1'b1;
                we  = 1'b0;
            end
        endcase
    endtask

    task automatic mwb(input logic [7:0] opc, input logic [15:0] a, input logic [15:0] b,
                       input logic we, input logic [4:0] mask, input logic [3:0] rd);
        logic [4:0] p;
        p = psr_fn(opc, a, b);
        if (we && !(R0Z && rd == 4'h0)) mr[rd] = alu_fn(opc, a, b);
        mpsr = (mpsr & ~mask) | (p & mask);
    endtask

    task automatic run_instr(input logic [15:0] ins);
        logic        ill, we;
        logic [7:0]  opc;
        logic [15:0] a, b;
        logic [4:0]  mask;
        logic [3:0]  rd;
        @(negedge clock);
        rd = ins[11:8];
        mdec(ins, ill, opc, a, b, we, mask);
        chk("ready_idle", 16'(instr_ready), 16'h1);
        instr       = ins;
        instr_valid = 1'b1;
        @(posedge clock);
        #1;
        instr_valid = 1'b0;
        instr       = 16'($urandom);
        if (ill) begin
            chk("illegal_pulse", 16'(illegal), 16'h1);
            chk("ready_on_illegal", 16'(instr_ready), 16'h1);
            chk("opc_on_illegal", 16'(alu_opcode), 16'h0);
            @(posedge clock);
            #1;
            chk("illegal_end", 16'(illegal), 16'h0);
            chk("psr_after_illegal", 16'(psr), 16'(mpsr));
            dbg_chk("rd_after_illegal", rd);
        end else begin
            chk("issue_opcode", 16'(alu_opcode), 16'(opc));
            chk("issue_a", alu_a, a);
            chk("issue_b", alu_b, b);
            chk("ready_issue", 16'(instr_ready), 16'h0);
            chk("no_illegal", 16'(illegal), 16'h0);
            @(posedge clock);
            #1;
            chk("wb_opcode_held", 16'(alu_opcode), 16'(opc));
            chk("ready_wb", 16'(instr_ready), 16'h0);
            dbg_chk("rd_before_wb", rd);
            @(posedge clock);
            #1;
            mwb(opc, a, b, we, mask, rd);
            chk("ready_after_wb", 16'(instr_ready), 16'h1);
            chk("idle_opcode", 16'(alu_opcode), 16'h0);
            chk("psr_after_wb", 16'(psr), 16'(mpsr));
            dbg_chk("rd_after_wb", rd);
        end
    endtask

    initial begin
        model_reset();
        // Reset held for two edges.
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        chk("rst_ready", 16'(instr_ready), 16'h1);
        chk("rst_opcode", 16'(alu_opcode), 16'h0);
        chk("rst_a", alu_a, 16'h0);
        chk("rst_b", alu_b, 16'h0);
        chk("rst_psr", 16'(psr), 16'h0);
        chk("rst_illegal", 16'(illegal), 16'h0);
        sweep("rst_regs");

        // LUI R1,0x12 then ADDI R1,+3 and ADDI R2,-1.
        run_instr(16'hF112);
        run_instr(16'h5103);
        run_instr(16'h52FF);
        dbg_chk("addi_neg_r2", 4'h2);

        // MOVI R3,5 then CMPI R3,5: Z set, R3 untouched.
        run_instr(16'hD305);
        run_instr(16'hB305);
        chk("cmpi_z_set", 16'(psr[3]), 16'h1);
        dbg_chk("cmpi_r3_kept", 4'h3);

        // Register form ops, shift, register CMP, illegal load/store.
        run_instr(16'h0453);
        run_instr(16'h8412);
        run_instr(16'h01B2);
        run_instr(16'h4123);
        run_instr(16'h7ABC);

        // Busy: instr_valid held through ISSUE/WB; B reads A's result.
        @(negedge clock);
        mdec(16'hD607, bi, bo, ba, bb, bw, bm);
        instr       = 16'hD607;
        instr_valid = 1'b1;
        @(posedge clock);
        #1;
        chk("busy_a_opcode", 16'(alu_opcode), 16'(bo));
        instr = 16'h0656;
        @(posedge clock);
        #1;
        chk("busy_wb_hold_b", alu_b, bb);
        chk("busy_wb_ready", 16'(instr_ready), 16'h0);
        @(posedge clock);
        #1;
        mwb(bo, ba, bb, bw, bm, 4'h6);
        chk("busy_idle_ready", 16'(instr_ready), 16'h1);
        chk("busy_idle_opcode", 16'(alu_opcode), 16'h0);
        dbg_chk("busy_r6_a", 4'h6);
        mdec(16'h0656, bi, bo, ba, bb, bw, bm);
        @(posedge clock);
        #1;
        instr_valid = 1'b0;
        chk("busy_b_opcode", 16'(alu_opcode), 16'(bo));
        chk("busy_b_a", alu_a, ba);
        chk("busy_b_b", alu_b, bb);
        @(posedge clock);
        @(posedge clock);
        #1;
        mwb(bo, ba, bb, bw, bm, 4'h6);
        dbg_chk("busy_r6_b", 4'h6);
        chk("busy_psr", 16'(psr), 16'(mpsr));

        // Random instruction stream.
        for (int n = 0; n < 60; n++) begin
            run_instr(16'($urandom));
            if (n % 15 == 14) sweep("rand_regs");
        end

        // Reset asserted during WB aborts the write.
        @(negedge clock);
        instr       = 16'hF934;
        instr_valid = 1'b1;
        @(posedge clock);
        #1;
        instr_valid = 1'b0;
        @(posedge clock);
        #1;
        chk("abort_in_wb", 16'(instr_ready), 16'h0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        dbg_chk("abort_r9", 4'h9);
        chk("abort_psr", 16'(psr), 16'h0);
        chk("abort_ready", 16'(instr_ready), 16'h1);
        chk("abort_opcode", 16'(alu_opcode), 16'h0);
        @(posedge clock);
        #1;
        dbg_chk("abort_r9_later", 4'h9);
        run_instr(16'hF934);
        sweep("final_regs");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
